// File: rtl/butterfly_mem_arbiter.sv
// rtl/butterfly_mem_arbiter.sv - IF/LSU arbiter onto one unified memory port
// LSU has fixed priority; a starvation counter forces an IF grant after MAX_LSU_BURST LSU wins.
module butterfly_mem_arbiter #(
  parameter int MAX_LSU_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wstrb_i,
  output logic        lsu_ready_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_LSU = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_LSU_BURST);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_cnt_nxt;
  logic       w_gnt_if;
  logic       w_gnt_lsu;
  logic       w_lsu_wins;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // LSU only loses a contested decision once the counter has reached the burst limit.
  assign w_lsu_wins = lsu_valid_i && (!if_valid_i || (r_starve_cnt < LP_MAX_BURST));

  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (w_lsu_wins) begin
          w_state_nxt = GNT_LSU;
          // A contested LSU win implies cnt < max, so the increment saturates at max.
          w_starve_cnt_nxt = if_valid_i ? (r_starve_cnt + 4'd1) : 4'd0;
        end else if (if_valid_i) begin
          w_state_nxt      = GNT_IF;
          w_starve_cnt_nxt = 4'd0;
        end else begin
          w_starve_cnt_nxt = 4'd0;
        end
      end
      GNT_IF, GNT_LSU: begin
        if (mem_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_gnt_if  = (r_state == GNT_IF);
  assign w_gnt_lsu = (r_state == GNT_LSU);

  // Payload is muxed straight from the owner; requesters hold it stable until ready.
  assign mem_valid_o = w_gnt_if || w_gnt_lsu;
  assign mem_we_o    = w_gnt_lsu && lsu_we_i;
  assign mem_addr_o  = w_gnt_if ? if_addr_i : (w_gnt_lsu ? lsu_addr_i : 32'd0);
  assign mem_wdata_o = w_gnt_lsu ? lsu_wdata_i : 32'd0;
  assign mem_wstrb_o = (w_gnt_lsu && lsu_we_i) ? lsu_wstrb_i : 4'b0000;

  assign if_ready_o  = w_gnt_if && mem_ready_i;
  assign if_rdata_o  = (w_gnt_if && mem_ready_i) ? mem_rdata_i : 32'd0;
  assign lsu_ready_o = w_gnt_lsu && mem_ready_i;
  assign lsu_rdata_o = (w_gnt_lsu && mem_ready_i) ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_butterfly_mem_arbiter.sv
// tb/tb_butterfly_mem_arbiter.sv - directed scoreboard bench for butterfly_mem_arbiter
module tb_butterfly_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        lsu_valid_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wstrb_i;
  logic        lsu_ready_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t sb[$];

  butterfly_mem_arbiter #(.MAX_LSU_BURST(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .if_valid_i  (if_valid_i),
    .if_addr_i   (if_addr_i),
    .if_ready_o  (if_ready_o),
    .if_rdata_o  (if_rdata_o),
    .lsu_valid_i (lsu_valid_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_wstrb_i (lsu_wstrb_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic exp_if(input logic [31:0] addr);
    txn_t t;
    t.is_if = 1'b1; t.addr = addr; t.we = 1'b0; t.wdata = 32'd0; t.wstrb = 4'b0000;
    sb.push_back(t);
  endtask

  task automatic exp_lsu(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    txn_t t;
    t.is_if = 1'b0; t.addr = addr; t.we = we;
    t.wdata = wdata; t.wstrb = we ? wstrb : 4'b0000;
    sb.push_back(t);
  endtask

  task automatic drive_lsu(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    lsu_valid_i = 1'b1;
    lsu_addr_i  = addr;
    lsu_we_i    = we;
    lsu_wdata_i = wdata;
    lsu_wstrb_i = wstrb;
  endtask

  task automatic chk_payload(input txn_t e);
    chk1("mem_valid", mem_valid_o, 1'b1);
    chk("mem_addr", mem_addr_o, e.addr);
    chk1("mem_we", mem_we_o, e.we);
    chk("mem_wdata", mem_wdata_o, e.wdata);
    chk("mem_wstrb", {28'd0, mem_wstrb_o}, {28'd0, e.wstrb});
  endtask

  // Waits for the next grant, checks it against the scoreboard head, completes it, drops owner valid.
  task automatic serve(input int waits, input logic [31:0] rd);
    txn_t e;
    int   n = 0;
    while (mem_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk1("grant_seen", (n < 20), 1'b1);
    chk1("sb_nonempty", (sb.size() != 0), 1'b1);
    if (n >= 20 || sb.size() == 0) return;
    e = sb.pop_front();
    mem_rdata_i = rd;
    for (int i = 0; i < waits; i++) begin
      chk_payload(e);
      chk1("if_ready_wait", if_ready_o, 1'b0);
      chk1("lsu_ready_wait", lsu_ready_o, 1'b0);
      chk("if_rdata_wait", if_rdata_o, 32'd0);
      chk("lsu_rdata_wait", lsu_rdata_o, 32'd0);
      step();
    end
    chk_payload(e);
    mem_ready_i = 1'b1;
    #1;
    chk1("if_ready_done", if_ready_o, e.is_if);
    chk1("lsu_ready_done", lsu_ready_o, !e.is_if);
    chk("if_rdata_done", if_rdata_o, e.is_if ? rd : 32'd0);
    chk("lsu_rdata_done", lsu_rdata_o, e.is_if ? 32'd0 : rd);
    step();
    chk1("bubble_valid", mem_valid_o, 1'b0);
    chk1("bubble_if_ready", if_ready_o, 1'b0);
    chk1("bubble_lsu_ready", lsu_ready_o, 1'b0);
    mem_ready_i = 1'b0;
    if (e.is_if) if_valid_i = 1'b0;
    else lsu_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_n_i = 1'b0;
    if_valid_i = 1'b0; if_addr_i = 32'd0;
    lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'd0;
    lsu_wdata_i = 32'd0; lsu_wstrb_i = 4'd0;
    mem_rdata_i = 32'd0; mem_ready_i = 1'b0;
    step();
    step();
    chk1("reset_outputs", |{if_ready_o, if_rdata_o, lsu_ready_o, lsu_rdata_o, mem_valid_o,
                            mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, 1'b0);
    rst_n_i = 1'b1;
    step();

    // IF only, two wait states
    if_valid_i = 1'b1; if_addr_i = 32'h100;
    exp_if(32'h100);
    serve(2, 32'h00500093);

    // Simultaneous IF and LSU store: LSU first, IF after one bubble
    if_valid_i = 1'b1; if_addr_i = 32'h200;
    drive_lsu(32'h1000, 1'b1, 32'hDEADBEEF, 4'b0011);
    exp_lsu(32'h1000, 1'b1, 32'hDEADBEEF, 4'b0011);
    exp_if(32'h200);
    serve(0, 32'h11111111);
    serve(0, 32'h22222222);

    // Starvation: IF held, LSU back-to-back; two rounds prove the counter restarts
    n = 0;
    if_valid_i = 1'b1; if_addr_i = 32'h300;
    drive_lsu(32'h4000, 1'b0, 32'd0, 4'b1111);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_lsu(32'h4000 + 32'(4 * n), 1'b0, 32'd0, 4'b1111);
        serve(0, 32'hA0000000 + 32'(n));
        n++;
        drive_lsu(32'h4000 + 32'(4 * n), 1'b0, 32'd0, 4'b1111);
      end
      exp_if(32'h300);
      serve(0, 32'h0000BEEF);
      if_valid_i = 1'b1;
    end
    exp_lsu(32'h4000 + 32'(4 * n), 1'b0, 32'd0, 4'b1111);
    serve(0, 32'h5A5A5A5A);
    exp_if(32'h300);
    serve(0, 32'h0000CAFE);

    // Load with strobes set: memory must see 0000, data only on the pulse
    drive_lsu(32'h2004, 1'b0, 32'hFFFFFFFF, 4'b1111);
    exp_lsu(32'h2004, 1'b0, 32'hFFFFFFFF, 4'b1111);
    serve(1, 32'h12345678);

    // Reset during GNT_LSU before completion
    drive_lsu(32'h3000, 1'b0, 32'd0, 4'b0000);
    exp_lsu(32'h3000, 1'b0, 32'd0, 4'b0000);
    step();
    step();
    chk1("pre_rst_valid", mem_valid_o, 1'b1);
    chk("pre_rst_addr", mem_addr_o, 32'h3000);
    rst_n_i = 1'b0;
    #1;
    chk1("rst_async_outputs", |{if_ready_o, if_rdata_o, lsu_ready_o, lsu_rdata_o, mem_valid_o,
                                mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, 1'b0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h99999999;
    #1;
    chk1("rst_no_lsu_ready", lsu_ready_o, 1'b0);
    step();
    chk1("rst_hold_valid", mem_valid_o, 1'b0);
    mem_ready_i = 1'b0;
    rst_n_i = 1'b1;
    serve(1, 32'hCAFEF00D);

    // mem_ready_i held high with no requests
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("idle_valid", mem_valid_o, 1'b0);
      chk1("idle_if_ready", if_ready_o, 1'b0);
      chk1("idle_lsu_ready", lsu_ready_o, 1'b0);
    end
    mem_ready_i = 1'b0;

    chk1("sb_drained", (sb.size() == 0), 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
